fetch_unit: RTL and testbench

Instruction fetch stage that sits between the instruction memory and the instruction register/decode stage. It owns the fetch PC, issues word requests to a variable-latency instruction memory and buffers returned words with their PCs in a small prefetch FIFO. It hands instructions downstream over a valid/ready handshake. Branch, jal and jalr redirects from execute flush the FIFO and restart fetch at the target. A halt word (0xFFFFFFFF) stops further fetching.

---
 rtl/fetch_unit.sv | 232 +++++++++++++++++++++++
 tb/tb_fetch_unit.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. Owns the fetch PC and issues word requests to a
// variable-latency instruction memory, with at most one request in flight.
// Returned words are buffered together with their PCs in a small prefetch
// FIFO. The FIFO head is offered to decode over a valid/ready handshake.
// A redirect from execute flushes the FIFO, discards any response still in
// flight and restarts fetch at the target. Fetching the halt word stops
// further requests until the next redirect.
//
// Parameters:
//   RESET_PC   fetch PC after reset
//   DEPTH      prefetch FIFO entries (power of 2, >= 2)
//   HALT_WORD  instruction encoding that stops fetch
//
// Ports:
//   clock, reset                      rising-edge clock, async active-high reset
//   imem_req/imem_addr/imem_gnt       request channel to instruction memory
//   imem_rvalid/imem_rdata            response channel from instruction memory
//   instr_valid/instr_ready           handshake towards decode
//   instr/instr_pc                    head instruction word and its PC
//   redirect_valid/redirect_target    flush and restart fetch at target
//   halted                            halt word fetched, no new requests
//
// Optional build macro FETCH_PERF_CNT_EN adds three saturating 32-bit
// counters as outputs: perf_fetched, perf_flushed, perf_stall.
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 4,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed,
  output logic [31:0] perf_stall
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    WAIT   = 2'd1,
    DROP   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [31:0]     fetch_pc_reg, fetch_pc_next;
  logic [31:0]     req_pc_reg;   // PC of the request currently in flight
  logic            run_reg;      // low during reset and up to the first edge after it

  logic [PW-1:0]   rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic [31:0]     word_mem [DEPTH];
  logic [31:0]     pc_mem   [DEPTH];

  logic            grant;
  logic            enq;
  logic            deq;
  logic            in_flight;

  // ---------------------------------------------------------------------------
  // Request / handshake decode
  // ---------------------------------------------------------------------------
  // In FETCH nothing is outstanding, so count alone decides whether a slot
  // can be reserved for the next response.
  assign imem_req    = run_reg && (state_reg == FETCH) && (count_reg < CW'(DEPTH));
  assign imem_addr   = fetch_pc_reg;
  assign grant       = imem_req && imem_gnt;

  assign instr_valid = (count_reg != '0);
  assign instr       = instr_valid ? word_mem[rd_ptr_reg] : '0;
  assign instr_pc    = instr_valid ? pc_mem[rd_ptr_reg]   : '0;
  assign halted      = (state_reg == HALTED);

  // A response arriving together with a redirect belongs to the old stream.
  assign enq = (state_reg == WAIT) && imem_rvalid && !redirect_valid;
  assign deq = instr_valid && instr_ready;

  // A response is still owed after this cycle: a fresh grant, or a pending
  // response that is not arriving right now.
  assign in_flight = grant ||
                     (((state_reg == WAIT) || (state_reg == DROP)) && !imem_rvalid);

  // ---------------------------------------------------------------------------
  // FSM next state and fetch PC
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    unique case (state_reg)
      FETCH: begin
        if (grant) begin
          fetch_pc_next = fetch_pc_reg + 32'd4;
          state_next    = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_next = (imem_rdata == HALT_WORD) ? HALTED : FETCH;
        end
      end
      DROP: begin
        if (imem_rvalid) begin
          state_next = FETCH;
        end
      end
      HALTED: begin
        state_next = HALTED;
      end
      default: begin
        state_next = FETCH;
      end
    endcase

    // Redirect overrides everything; an owed response must be swallowed by DROP.
    if (redirect_valid) begin
      fetch_pc_next = redirect_target & ~32'h3;
      state_next    = in_flight ? DROP : FETCH;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= FETCH;
      fetch_pc_reg <= RESET_PC & ~32'h3;
      req_pc_reg   <= RESET_PC & ~32'h3;
      run_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      run_reg      <= 1'b1;
      if (grant) begin
        req_pc_reg <= fetch_pc_reg;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Prefetch FIFO control
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (redirect_valid) begin
      // Any dequeue this cycle has already been seen by decode; the flush
      // simply empties what remains.
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (enq) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (deq) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      unique case ({enq, deq})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset: instr/instr_pc are forced to 0 while empty.
  always_ff @(posedge clock) begin
    if (enq) begin
      word_mem[wr_ptr_reg] <= imem_rdata;
      pc_mem[wr_ptr_reg]   <= req_pc_reg;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Performance counters (saturating)
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

  logic        drop_resp;
  logic [31:0] flush_amt;

  // One response is discarded when the redirect catches a fresh grant or a
  // WAIT (pending or arriving now). In DROP it was already counted on entry.
  assign drop_resp = grant || (state_reg == WAIT);
  assign flush_amt = 32'(count_reg) - 32'(deq) + 32'(drop_resp);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
      perf_stall   <= '0;
    end else begin
      if (enq) begin
        perf_fetched <= sat_add(perf_fetched, 32'd1);
      end
      if (redirect_valid) begin
        perf_flushed <= sat_add(perf_flushed, flush_amt);
      end
      if ((count_reg == CW'(DEPTH)) && (state_reg != HALTED)) begin
        perf_stall <= sat_add(perf_stall, 32'd1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] HALT     = 32'hFFFF_FFFF;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clock;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
  logic [31:0] perf_stall;
`endif

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .HALT_WORD(HALT)) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .halted         (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushed   (perf_flushed),
    .perf_stall     (perf_stall)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: expected FIFO contents, sequential-PC rule and halt status.
  typedef struct {
    logic [31:0] w;
    logic [31:0] pc;
  } ent_t;
  ent_t        q[$];
  logic [31:0] exp_pc;
  bit          halt_seen;
  int          n_accept;

  // Memory model: single outstanding response with fixed latency.
  bit          pend, pend_stale;
  int          left;
  logic [31:0] pend_addr;
  int          lat    = 1;
  bit          gnt_en = 1'b1;
  bit          halt_en = 1'b0;
  logic [31:0] halt_addr = 32'h8;

  // Stimulus controls.
  bit          rdy_drv   = 1'b1;
  bit          redir_drv = 1'b0;
  logic [31:0] tgt_drv   = '0;
  bit          in_reset  = 1'b1;

  // Logs of delivered instructions and granted addresses.
  logic [31:0] dl_pc[$];
  logic [31:0] dl_w[$];
  logic [31:0] ga[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (halt_en && a == halt_addr) ? HALT : a + 32'h100;
  endfunction

  function automatic logic [31:0] at(input logic [31:0] qq[$], input int i);
    return (i < qq.size()) ? qq[i] : 32'hxxxx_xxxx;
  endfunction

  // One clock cycle: check outputs, drive inputs, advance the model.
  task automatic step();
    bit          deq, accept, resp_stale;
    logic [31:0] resp_addr;
    ent_t        e;
    @(negedge clock);
    if (!in_reset) begin
      chk("instr_valid", 32'(instr_valid), 32'(q.size() > 0));
      if (q.size() > 0) begin
        chk("instr", instr, q[0].w);
        chk("instr_pc", instr_pc, q[0].pc);
      end
      chk("addr_align", {30'b0, imem_addr[1:0]}, 32'h0);
      chk("halted", 32'(halted), 32'(halt_seen));
      if (halt_seen) chk("req_when_halted", 32'(imem_req), 32'h0);
      if (pend && !pend_stale) chk("req_while_pending", 32'(imem_req), 32'h0);
      if (q.size() >= DEPTH) chk("req_when_full", 32'(imem_req), 32'h0);
    end
    // memory response
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    resp_stale  = pend_stale;
    resp_addr   = pend_addr;
    if (pend) begin
      if (left == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr);
        pend        = 1'b0;
      end else begin
        left--;
      end
    end
    // grant
    imem_gnt = gnt_en && !in_reset;
    if (imem_req && imem_gnt) begin
      pend       = 1'b1;
      pend_stale = 1'b0;
      left       = lat - 1;
      pend_addr  = imem_addr;
      ga.push_back(imem_addr);
    end
    instr_ready     = rdy_drv;
    redirect_valid  = redir_drv;
    redirect_target = tgt_drv;
    redir_drv       = 1'b0;
    // downstream handshake
    deq = instr_valid && instr_ready && !in_reset;
    if (deq) begin
      if (q.size() > 0) e = q.pop_front();
      dl_pc.push_back(instr_pc);
      dl_w.push_back(instr);
      chk("deliver_pc_seq", instr_pc, exp_pc);
      exp_pc = exp_pc + 32'd4;
    end
    accept = imem_rvalid && !resp_stale && !redirect_valid && !in_reset;
    if (accept) begin
      q.push_back('{imem_rdata, resp_addr});
      n_accept++;
      if (imem_rdata == HALT) halt_seen = 1'b1;
    end
    if (redirect_valid) begin
      q.delete();
      exp_pc    = redirect_target & ~32'h3;
      halt_seen = 1'b0;
      if (pend) pend_stale = 1'b1;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"}, 32'(imem_req), 32'h0);
    chk({tag, "_valid"}, 32'(instr_valid), 32'h0);
    chk({tag, "_halted"}, 32'(halted), 32'h0);
    chk({tag, "_instr"}, instr, 32'h0);
    chk({tag, "_pc"}, instr_pc, 32'h0);
    chk({tag, "_addr"}, imem_addr, RESET_PC);
  endtask

  // Asynchronous reset a little after a rising edge, checked before any edge.
  task automatic do_reset();
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    q.delete();
    exp_pc    = RESET_PC;
    halt_seen = 1'b0;
    n_accept  = 0;
    if (pend) pend_stale = 1'b1;
    in_reset = 1'b1;
    step();
    step();
    reset    = 1'b0;
    in_reset = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] t);
    tgt_drv   = t;
    redir_drv = 1'b1;
    step();
  endtask

  task automatic wait_pending(input string name);
    int g = 0;
    while (!(pend && !pend_stale && left > 0) && g < 50) begin
      step();
      g++;
    end
    chk(name, 32'(pend && !pend_stale && left > 0), 32'h1);
  endtask

  initial begin
    reset           = 1'b1;
    imem_gnt        = 1'b0;
    imem_rvalid     = 1'b0;
    imem_rdata      = '0;
    instr_ready     = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    exp_pc          = RESET_PC;
    halt_seen       = 1'b0;
    n_accept        = 0;
    pend            = 1'b0;
    pend_stale      = 1'b0;
    left            = 0;
    pend_addr       = '0;

    // power-on reset
    step();
    step();
    check_reset_outputs("por");
    reset    = 1'b0;
    in_reset = 1'b0;

    // basic in-order fetch, 1-cycle memory latency
    dl_pc.delete(); dl_w.delete();
    run(15);
    chk("t1_pc0", at(dl_pc, 0), 32'h0);
    chk("t1_pc1", at(dl_pc, 1), 32'h4);
    chk("t1_pc2", at(dl_pc, 2), 32'h8);
    chk("t1_w0", at(dl_w, 0), 32'h100);
    chk("t1_w1", at(dl_w, 1), 32'h104);
    chk("t1_w2", at(dl_w, 2), 32'h108);

    // backpressure: exactly DEPTH words prefetched, then resume at PC 16
    rdy_drv = 1'b0;
    redirect_to(32'h0);
    ga.delete();
    run(20);
    chk("t2_grants", 32'(ga.size()), 32'd4);
    chk("t2_req_idle", 32'(imem_req), 32'h0);
    chk("t2_model_full", 32'(q.size()), 32'd4);
    rdy_drv = 1'b1;
    dl_pc.delete(); dl_w.delete(); ga.delete();
    run(20);
    chk("t2_pc0", at(dl_pc, 0), 32'h0);
    chk("t2_pc3", at(dl_pc, 3), 32'hC);
    chk("t2_pc4", at(dl_pc, 4), 32'h10);
    chk("t2_w4", at(dl_w, 4), 32'h110);
    chk("t2_resume_addr", at(ga, 0), 32'h10);

    // redirect with a response in flight, 3-cycle latency
    lat = 3;
    wait_pending("t3_wait_pending");
    redirect_to(32'h40);
    dl_pc.delete(); dl_w.delete();
    step();
    chk("t3_empty_after_redirect", 32'(instr_valid), 32'h0);
    run(30);
    chk("t3_pc0", at(dl_pc, 0), 32'h40);
    chk("t3_w0", at(dl_w, 0), 32'h140);
    redirect_to(32'h43);
    dl_pc.delete(); dl_w.delete();
    run(30);
    chk("t3_unaligned_pc0", at(dl_pc, 0), 32'h40);

    // halt word at PC 8
    lat       = 1;
    halt_en   = 1'b1;
    halt_addr = 32'h8;
    redirect_to(32'h0);
    dl_pc.delete(); dl_w.delete(); ga.delete();
    run(30);
    chk("t4_halted", 32'(halted), 32'h1);
    chk("t4_req_off", 32'(imem_req), 32'h0);
    chk("t4_delivered", 32'(dl_pc.size()), 32'd3);
    chk("t4_grants", 32'(ga.size()), 32'd3);
    chk("t4_halt_pc", at(dl_pc, 2), 32'h8);
    chk("t4_halt_word", at(dl_w, 2), HALT);
    halt_en = 1'b0;
    redirect_to(32'h0);
    dl_pc.delete(); dl_w.delete();
    run(20);
    chk("t4_unhalted", 32'(halted), 32'h0);
    chk("t4_refetch_pc", at(dl_pc, 0), 32'h0);
    chk("t4_refetch_w", at(dl_w, 0), 32'h100);

    // reset in WAIT; the late response must be ignored
    lat = 3;
    begin
      int g = 0;
      while (!(pend && !pend_stale && left == 2) && g < 50) begin
        step();
        g++;
      end
      chk("t5_wait_grant", 32'(pend && !pend_stale && left == 2), 32'h1);
    end
    do_reset();
    gnt_en = 1'b0;
    run(4);
    chk("t5_stale_ignored", 32'(instr_valid), 32'h0);
    gnt_en = 1'b1;
    dl_pc.delete(); dl_w.delete();
    run(30);
    chk("t5_pc0", at(dl_pc, 0), RESET_PC);
    chk("t5_w0", at(dl_w, 0), RESET_PC + 32'h100);

`ifdef FETCH_PERF_CNT_EN
    // perf counters: 3 fetched, flush 2 queued + 1 in flight
    rdy_drv = 1'b0;
    do_reset();
    begin
      int g = 0;
      while (n_accept < 3 && g < 60) begin
        step();
        g++;
      end
      chk("t6_three_fetched", 32'(n_accept), 32'd3);
    end
    rdy_drv = 1'b1;
    step();
    rdy_drv = 1'b0;
    wait_pending("t6_wait_pending");
    redirect_to(32'h200);
    step();
    chk("t6_perf_fetched", perf_fetched, 32'd3);
    chk("t6_perf_flushed", perf_flushed, 32'd3);
    rdy_drv = 1'b1;
    run(10);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
